rv_multicycle_ctrl: RTL and testbench
=====================================

Name: rv_multicycle_ctrl

Overview:
Multi-cycle control FSM for the RV32I core. Sequences fetch, decode, execute, memory and writeback over a shared single-port memory and a single ALU. Decodes opcode/funct3/funct7 from the instruction register and drives every datapath select, write-enable and memory handshake. Also counts retired instructions and flags illegal encodings.

Parameters:
CNT_W, 32, width of retired-instruction counter (wraps modulo 2^CNT_W)

Ports:
clk  in  1  core clock, rising edge
rst_n  in  1  asynchronous active-low reset
instr_i  in  32  instruction register contents (valid from DECODE onward)
mem_ready_i  in  1  memory accepts request / read data valid this cycle
branch_taken_i  in  1  datapath comparator result for branch_cmp_o
ir_we_o  out  1  load instruction register from memory read data
pc_we_o  out  1  update PC
pc_sel_o  out  2  0=PC+4, 1=PC+imm, 2=ALU result with bit0 cleared
mem_req_o  out  1  memory request, held until mem_ready_i
mem_we_o  out  1  store when mem_req_o
mem_addr_sel_o  out  1  0=PC, 1=ALU result register
mem_funct3_o  out  3  access size/sign (instr_i[14:12])
alu_op_o  out  4  0 ADD,1 SUB,2 SLL,3 SLT,4 SLTU,5 XOR,6 SRL,7 SRA,8 OR,9 AND,10 PASS_B
alu_a_sel_o  out  2  0=rs1, 1=PC, 2=zero
alu_b_sel_o  out  1  0=rs2, 1=immediate
imm_type_o  out  3  0 I,1 S,2 B,3 U,4 J
branch_cmp_o  out  3  instr_i[14:12] during branch EXECUTE
reg_we_o  out  1  register-file write
wb_sel_o  out  2  0=ALU result, 1=load data, 2=PC+4
illegal_instr_o  out  1  sticky illegal-instruction flag
retire_o  out  1  one-cycle pulse per completed instruction
instret_o  out  CNT_W  retired-instruction count

Behaviour:
- States: FETCH, DECODE, EXECUTE, MEM, WRITEBACK, TRAP. Reset state FETCH.
- Reset (async, any state, mid-transaction included): state=FETCH, instret_o=0, illegal_instr_o=0. All enables/req outputs=0 and all selects=0 immediately, because outputs are combinational from state and latched fields.
- FETCH: mem_req_o=1, mem_addr_sel_o=0, mem_we_o=0. Stay while mem_ready_i=0. On mem_ready_i=1: ir_we_o=1, go to DECODE.
- DECODE: classify instr_i[6:0]:
  - R: 0110011
  - I-ALU: 0010011
  - LOAD: 0000011
  - STORE: 0100011
  - BRANCH: 1100011
  - JAL: 1101111
  - JALR: 1100111
  - LUI: 0110111
  - AUIPC: 0010111
  - Illegal: unknown opcode; R funct7 not 0000000/0100000, or 0100000 with funct3 other than 000/101; SLLI funct7≠0; SRLI/SRAI funct7 not 0000000/0100000; LOAD funct3 ∈{011,110,111}; STORE funct3>010; BRANCH funct3 ∈{010,011}; JALR funct3≠000.
  - Illegal → TRAP, else → EXECUTE.
- EXECUTE, by class:
  - R/I-ALU: alu_op from funct3/funct7[5]; SUB only for R-type; SRAI uses funct7[5]. → WRITEBACK.
  - LOAD/STORE: ADD, a=rs1, b=imm (I / S). → MEM.
  - BRANCH: pc_we_o=1, pc_sel_o = branch_taken_i ? 1 : 0, imm_type B, retire. → FETCH.
  - JAL: reg_we_o (wb_sel 2), pc_sel 1, imm J, pc_we, retire. → FETCH.
  - JALR: ALU ADD rs1+imm I, reg_we_o (wb_sel 2), pc_sel 2, pc_we, retire. → FETCH. rd is written with the old PC+4.
  - LUI: a=zero, b=imm U, ADD. → WRITEBACK.
  - AUIPC: a=PC, b=imm U, ADD. → WRITEBACK.
- MEM: mem_req_o=1, mem_addr_sel_o=1, mem_we_o=STORE, mem_funct3_o=funct3. Hold while mem_ready_i=0.
  - On ready, STORE: pc_we (sel 0), retire → FETCH.
  - On ready, LOAD: → WRITEBACK.
- WRITEBACK: reg_we_o=1, wb_sel_o = LOAD ? 1 : 0, pc_we (sel 0), retire → FETCH.
- rd==0: reg_we_o forced 0; the instruction still retires.
- Outputs are fixed in each state regardless of mem_ready_i, except the ready-qualified outputs: ir_we_o, STORE pc_we_o/retire_o, and state advance.
- TRAP: illegal_instr_o=1 and all other outputs 0. Terminal until reset. No retire, no PC update.
- instret_o increments on the retire_o cycle and wraps all-ones→0.
- Cycle counts with mem_ready_i tied high: ALU/LUI/AUIPC 4, LOAD 5, STORE 4, BRANCH/JAL/JALR 3. Each memory wait cycle adds 1.

Test Plan:
- ADD x3,x1,x2 (0x002081B3), ready high → alu_op 0, reg_we in cycle 4, retire, pc_sel 0, instret 0→1.
- LW x5,8(x1) with mem_ready low 3 cycles in MEM → mem_req held 4 cycles, mem_addr_sel 1, funct3 010, then reg_we with wb_sel 1; total 8 cycles.
- BEQ taken vs not taken → pc_sel 1 vs 0, pc_we in cycle 3, no reg_we.
- JALR x1,0(x5) → reg_we, wb_sel 2, pc_sel 2 in the same EXECUTE cycle. ADDI x0,x0,1 → reg_we stays 0, retire still pulses.
- Opcode 0x0000007F → TRAP, illegal_instr 1 and sticky, no mem_req afterwards. rst_n low → illegal clears, FETCH restarts.
- rst_n asserted mid-MEM store → mem_req_o/mem_we_o drop asynchronously. After release, FETCH begins with instret_o=0.

Source files
------------

// File: rtl/rv_multicycle_ctrl.sv
// Multi-cycle RV32I control FSM: fetch/decode/execute/mem/writeback sequencing,
// datapath select generation, illegal-encoding trap and retired-instruction counter.
module rv_multicycle_ctrl #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [31:0]      instr_i,
    input  logic             mem_ready_i,
    input  logic             branch_taken_i,
    output logic             ir_we_o,
    output logic             pc_we_o,
    output logic [1:0]       pc_sel_o,
    output logic             mem_req_o,
    output logic             mem_we_o,
    output logic             mem_addr_sel_o,
    output logic [2:0]       mem_funct3_o,
    output logic [3:0]       alu_op_o,
    output logic [1:0]       alu_a_sel_o,
    output logic             alu_b_sel_o,
    output logic [2:0]       imm_type_o,
    output logic [2:0]       branch_cmp_o,
    output logic             reg_we_o,
    output logic [1:0]       wb_sel_o,
    output logic             illegal_instr_o,
    output logic             retire_o,
    output logic [CNT_W-1:0] instret_o
);

    localparam int unsigned OPC_W = 7;
    localparam int unsigned F3_W  = 3;
    localparam int unsigned F7_W  = 7;

    localparam logic [OPC_W-1:0] OPC_R      = 7'b0110011;
    localparam logic [OPC_W-1:0] OPC_IALU   = 7'b0010011;
    localparam logic [OPC_W-1:0] OPC_LOAD   = 7'b0000011;
    localparam logic [OPC_W-1:0] OPC_STORE  = 7'b0100011;
    localparam logic [OPC_W-1:0] OPC_BRANCH = 7'b1100011;
    localparam logic [OPC_W-1:0] OPC_JAL    = 7'b1101111;
    localparam logic [OPC_W-1:0] OPC_JALR   = 7'b1100111;
    localparam logic [OPC_W-1:0] OPC_LUI    = 7'b0110111;
    localparam logic [OPC_W-1:0] OPC_AUIPC  = 7'b0010111;

    localparam logic [F7_W-1:0] F7_BASE = 7'b0000000;
    localparam logic [F7_W-1:0] F7_ALT  = 7'b0100000;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_SLL  = 4'd2;
    localparam logic [3:0] ALU_SLT  = 4'd3;
    localparam logic [3:0] ALU_SLTU = 4'd4;
    localparam logic [3:0] ALU_XOR  = 4'd5;
    localparam logic [3:0] ALU_SRL  = 4'd6;
    localparam logic [3:0] ALU_SRA  = 4'd7;
    localparam logic [3:0] ALU_OR   = 4'd8;
    localparam logic [3:0] ALU_AND  = 4'd9;

    localparam logic [2:0] IMM_I = 3'd0;
    localparam logic [2:0] IMM_S = 3'd1;
    localparam logic [2:0] IMM_B = 3'd2;
    localparam logic [2:0] IMM_U = 3'd3;
    localparam logic [2:0] IMM_J = 3'd4;

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXECUTE,
        S_MEM,
        S_WRITEBACK,
        S_TRAP
    } state_t;

    typedef enum logic [3:0] {
        C_R,
        C_IALU,
        C_LOAD,
        C_STORE,
        C_BRANCH,
        C_JAL,
        C_JALR,
        C_LUI,
        C_AUIPC,
        C_ILLEGAL
    } op_class_t;

    state_t            state_q, state_d;
    op_class_t         op_class_q, dec_class;
    logic [OPC_W-1:0]  opcode;
    logic [F3_W-1:0]   funct3;
    logic [F7_W-1:0]   funct7;
    logic              rd_zero;
    logic [3:0]        alu_fn;
    logic              unused_fields;

    assign opcode        = instr_i[6:0];
    assign funct3        = instr_i[14:12];
    assign funct7        = instr_i[31:25];
    assign rd_zero       = (instr_i[11:7] == 5'd0);
    assign unused_fields = ^instr_i[24:15];

    // Opcode classification with the reserved funct3/funct7 combinations mapped to illegal.
    always_comb begin
        dec_class = C_ILLEGAL;
        case (opcode)
            OPC_R: begin
                if (funct7 == F7_BASE ||
                    (funct7 == F7_ALT && (funct3 == 3'b000 || funct3 == 3'b101)))
                    dec_class = C_R;
            end
            OPC_IALU: begin
                if (funct3 == 3'b001) begin
                    if (funct7 == F7_BASE) dec_class = C_IALU;
                end else if (funct3 == 3'b101) begin
                    if (funct7 == F7_BASE || funct7 == F7_ALT) dec_class = C_IALU;
                end else begin
                    dec_class = C_IALU;
                end
            end
            OPC_LOAD: begin
                if (funct3 != 3'b011 && funct3 != 3'b110 && funct3 != 3'b111)
                    dec_class = C_LOAD;
            end
            OPC_STORE: begin
                if (funct3 <= 3'b010) dec_class = C_STORE;
            end
            OPC_BRANCH: begin
                if (funct3 != 3'b010 && funct3 != 3'b011) dec_class = C_BRANCH;
            end
            OPC_JAL:   dec_class = C_JAL;
            OPC_JALR: begin
                if (funct3 == 3'b000) dec_class = C_JALR;
            end
            OPC_LUI:   dec_class = C_LUI;
            OPC_AUIPC: dec_class = C_AUIPC;
            default:   dec_class = C_ILLEGAL;
        endcase
    end

    // ALU function for R/I arithmetic; SUB only exists in R-type, SRA/SRAI keyed on funct7[5].
    always_comb begin
        alu_fn = ALU_ADD;
        case (funct3)
            3'b000:  alu_fn = (op_class_q == C_R && funct7[5]) ? ALU_SUB : ALU_ADD;
            3'b001:  alu_fn = ALU_SLL;
            3'b010:  alu_fn = ALU_SLT;
            3'b011:  alu_fn = ALU_SLTU;
            3'b100:  alu_fn = ALU_XOR;
            3'b101:  alu_fn = funct7[5] ? ALU_SRA : ALU_SRL;
            3'b110:  alu_fn = ALU_OR;
            default: alu_fn = ALU_AND;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_FETCH;
        else        state_q <= state_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                  op_class_q <= C_R;
        else if (state_q == S_DECODE) op_class_q <= dec_class;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)        instret_o <= '0;
        else if (retire_o) instret_o <= instret_o + CNT_W'(1);
    end

    // Next state and combinational outputs; everything is forced low while reset is asserted.
    always_comb begin
        state_d         = state_q;
        ir_we_o         = 1'b0;
        pc_we_o         = 1'b0;
        pc_sel_o        = 2'd0;
        mem_req_o       = 1'b0;
        mem_we_o        = 1'b0;
        mem_addr_sel_o  = 1'b0;
        mem_funct3_o    = 3'd0;
        alu_op_o        = ALU_ADD;
        alu_a_sel_o     = 2'd0;
        alu_b_sel_o     = 1'b0;
        imm_type_o      = IMM_I;
        branch_cmp_o    = 3'd0;
        reg_we_o        = 1'b0;
        wb_sel_o        = 2'd0;
        illegal_instr_o = 1'b0;
        retire_o        = 1'b0;
        if (rst_n) begin
            case (state_q)
                S_FETCH: begin
                    mem_req_o = 1'b1;
                    if (mem_ready_i) begin
                        ir_we_o = 1'b1;
                        state_d = S_DECODE;
                    end
                end
                S_DECODE: begin
                    state_d = (dec_class == C_ILLEGAL) ? S_TRAP : S_EXECUTE;
                end
                S_EXECUTE: begin
                    state_d = S_WRITEBACK;
                    case (op_class_q)
                        C_R: alu_op_o = alu_fn;
                        C_IALU: begin
                            alu_op_o    = alu_fn;
                            alu_b_sel_o = 1'b1;
                            imm_type_o  = IMM_I;
                        end
                        C_LOAD: begin
                            alu_b_sel_o = 1'b1;
                            imm_type_o  = IMM_I;
                            state_d     = S_MEM;
                        end
                        C_STORE: begin
                            alu_b_sel_o = 1'b1;
                            imm_type_o  = IMM_S;
                            state_d     = S_MEM;
                        end
                        C_BRANCH: begin
                            pc_we_o      = 1'b1;
                            pc_sel_o     = {1'b0, branch_taken_i};
                            imm_type_o   = IMM_B;
                            branch_cmp_o = funct3;
                            retire_o     = 1'b1;
                            state_d      = S_FETCH;
                        end
                        C_JAL: begin
                            reg_we_o   = !rd_zero;
                            wb_sel_o   = 2'd2;
                            pc_sel_o   = 2'd1;
                            imm_type_o = IMM_J;
                            pc_we_o    = 1'b1;
                            retire_o   = 1'b1;
                            state_d    = S_FETCH;
                        end
                        C_JALR: begin
                            alu_b_sel_o = 1'b1;
                            imm_type_o  = IMM_I;
                            reg_we_o    = !rd_zero;
                            wb_sel_o    = 2'd2;
                            pc_sel_o    = 2'd2;
                            pc_we_o     = 1'b1;
                            retire_o    = 1'b1;
                            state_d     = S_FETCH;
                        end
                        C_LUI: begin
                            alu_a_sel_o = 2'd2;
                            alu_b_sel_o = 1'b1;
                            imm_type_o  = IMM_U;
                        end
                        C_AUIPC: begin
                            alu_a_sel_o = 2'd1;
                            alu_b_sel_o = 1'b1;
                            imm_type_o  = IMM_U;
                        end
                        default: state_d = S_TRAP;
                    endcase
                end
                S_MEM: begin
                    mem_req_o      = 1'b1;
                    mem_addr_sel_o = 1'b1;
                    mem_we_o       = (op_class_q == C_STORE);
                    mem_funct3_o   = funct3;
                    if (mem_ready_i) begin
                        if (op_class_q == C_STORE) begin
                            pc_we_o  = 1'b1;
                            retire_o = 1'b1;
                            state_d  = S_FETCH;
                        end else begin
                            state_d  = S_WRITEBACK;
                        end
                    end
                end
                S_WRITEBACK: begin
                    reg_we_o = !rd_zero;
                    wb_sel_o = (op_class_q == C_LOAD) ? 2'd1 : 2'd0;
                    pc_we_o  = 1'b1;
                    retire_o = 1'b1;
                    state_d  = S_FETCH;
                end
                S_TRAP: illegal_instr_o = 1'b1;
                default: state_d = S_FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_rv_multicycle_ctrl.sv
// Directed cycle-by-cycle bench for rv_multicycle_ctrl; every control output is
// compared each cycle against a hand-built expected control word.
module tb_rv_multicycle_ctrl;

    localparam int unsigned CNT_W = 32;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [31:0]      instr;
    logic             mem_ready;
    logic             branch_taken;
    logic             ir_we, pc_we, mem_req, mem_we, mem_addr_sel, alu_b_sel;
    logic             reg_we, illegal_instr, retire;
    logic [1:0]       pc_sel, alu_a_sel, wb_sel;
    logic [2:0]       mem_funct3, imm_type, branch_cmp;
    logic [3:0]       alu_op;
    logic [CNT_W-1:0] instret;

    typedef struct packed {
        logic       ir_we;
        logic       pc_we;
        logic [1:0] pc_sel;
        logic       mem_req;
        logic       mem_we;
        logic       mem_addr_sel;
        logic [2:0] mem_funct3;
        logic [3:0] alu_op;
        logic [1:0] alu_a_sel;
        logic       alu_b_sel;
        logic [2:0] imm_type;
        logic [2:0] branch_cmp;
        logic       reg_we;
        logic [1:0] wb_sel;
        logic       illegal;
        logic       retire;
    } ctl_t;

    int          vectors     = 0;
    int          miscompares = 0;
    int unsigned exp_ret     = 0;

    always #5 clk = ~clk;

    rv_multicycle_ctrl #(.CNT_W(CNT_W)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .instr_i         (instr),
        .mem_ready_i     (mem_ready),
        .branch_taken_i  (branch_taken),
        .ir_we_o         (ir_we),
        .pc_we_o         (pc_we),
        .pc_sel_o        (pc_sel),
        .mem_req_o       (mem_req),
        .mem_we_o        (mem_we),
        .mem_addr_sel_o  (mem_addr_sel),
        .mem_funct3_o    (mem_funct3),
        .alu_op_o        (alu_op),
        .alu_a_sel_o     (alu_a_sel),
        .alu_b_sel_o     (alu_b_sel),
        .imm_type_o      (imm_type),
        .branch_cmp_o    (branch_cmp),
        .reg_we_o        (reg_we),
        .wb_sel_o        (wb_sel),
        .illegal_instr_o (illegal_instr),
        .retire_o        (retire),
        .instret_o       (instret)
    );

    function automatic ctl_t observe();
        ctl_t c;
        c = '{ir_we, pc_we, pc_sel, mem_req, mem_we, mem_addr_sel, mem_funct3, alu_op,
              alu_a_sel, alu_b_sel, imm_type, branch_cmp, reg_we, wb_sel, illegal_instr, retire};
        return c;
    endfunction

    function automatic ctl_t fetch_ctl(input logic ready);
        ctl_t c;
        c         = '0;
        c.mem_req = 1'b1;
        c.ir_we   = ready;
        return c;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input string tag, input logic ready, input ctl_t e);
        @(negedge clk);
        mem_ready = ready;
        #1;
        check(tag, 64'(observe()), 64'(e));
    endtask

    // Fetch (ready high) and decode cycles shared by every instruction.
    task automatic front(input string tag, input logic [31:0] ins);
        @(negedge clk);
        instr     = ins;
        mem_ready = 1'b1;
        #1;
        check({tag, "/instret"}, 64'(instret), 64'(exp_ret));
        check({tag, "/fetch"}, 64'(observe()), 64'(fetch_ctl(1'b1)));
        step({tag, "/dec"}, 1'b1, '0);
    endtask

    task automatic run_wb(input string tag, input logic [31:0] ins, input logic [3:0] op,
                          input logic [1:0] asel, input logic bsel, input logic [2:0] imm,
                          input logic rwe);
        ctl_t e;
        front(tag, ins);
        e = '0; e.alu_op = op; e.alu_a_sel = asel; e.alu_b_sel = bsel; e.imm_type = imm;
        step({tag, "/ex"}, 1'b1, e);
        e = '0; e.reg_we = rwe; e.pc_we = 1'b1; e.retire = 1'b1;
        step({tag, "/wb"}, 1'b1, e);
        exp_ret++;
    endtask

    task automatic run_br(input string tag, input logic [31:0] ins, input logic taken,
                          input logic [2:0] f3);
        ctl_t e;
        front(tag, ins);
        branch_taken = taken;
        e = '0; e.pc_we = 1'b1; e.pc_sel = {1'b0, taken}; e.imm_type = 3'd2;
        e.branch_cmp = f3; e.retire = 1'b1;
        step({tag, "/ex"}, 1'b1, e);
        branch_taken = 1'b0;
        exp_ret++;
    endtask

    task automatic run_illegal(input string tag, input logic [31:0] ins);
        ctl_t e;
        front(tag, ins);
        e = '0; e.illegal = 1'b1;
        step({tag, "/trap0"}, 1'b1, e);
        step({tag, "/trap1"}, 1'b1, e);
        step({tag, "/trap2"}, 1'b0, e);
        check({tag, "/instret"}, 64'(instret), 64'(exp_ret));
        #1 rst_n = 1'b0;
        #1;
        check({tag, "/rst_clear"}, 64'(observe()), 64'(0));
        exp_ret = 0;
        check({tag, "/rst_cnt"}, 64'(instret), 64'(exp_ret));
        mem_ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check({tag, "/restart"}, 64'(observe()), 64'(fetch_ctl(1'b0)));
    endtask

    initial begin
        ctl_t        e;
        logic [31:0] bad [4];
        bad[0] = 32'h0000_007F;
        bad[1] = 32'h4020_9233;
        bad[2] = 32'h0002_90E7;
        bad[3] = 32'h0080_B283;

        rst_n        = 1'b0;
        instr        = 32'h0;
        mem_ready    = 1'b0;
        branch_taken = 1'b0;
        #3;
        check("reset_ctl", 64'(observe()), 64'(0));
        check("reset_cnt", 64'(instret), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("fetch_stall", 64'(observe()), 64'(fetch_ctl(1'b0)));

        run_wb("add",   32'h0020_81B3, 4'd0, 2'd0, 1'b0, 3'd0, 1'b1);
        run_wb("sub",   32'h4020_8233, 4'd1, 2'd0, 1'b0, 3'd0, 1'b1);
        run_wb("srai",  32'h4030_D293, 4'd7, 2'd0, 1'b1, 3'd0, 1'b1);
        run_wb("addi0", 32'h0010_0013, 4'd0, 2'd0, 1'b1, 3'd0, 1'b0);
        run_wb("lui",   32'h1234_53B7, 4'd0, 2'd2, 1'b1, 3'd3, 1'b1);
        run_wb("auipc", 32'h0000_1417, 4'd0, 2'd1, 1'b1, 3'd3, 1'b1);

        // LW x5,8(x1) with three memory wait cycles
        front("lw", 32'h0080_A283);
        e = '0; e.alu_b_sel = 1'b1;
        step("lw/ex", 1'b1, e);
        e = '0; e.mem_req = 1'b1; e.mem_addr_sel = 1'b1; e.mem_funct3 = 3'b010;
        for (int i = 0; i < 3; i++) step("lw/mem_wait", 1'b0, e);
        step("lw/mem_rdy", 1'b1, e);
        e = '0; e.reg_we = 1'b1; e.wb_sel = 2'd1; e.pc_we = 1'b1; e.retire = 1'b1;
        step("lw/wb", 1'b1, e);
        exp_ret++;

        // SW x2,4(x1) with one wait cycle
        front("sw", 32'h0020_A223);
        e = '0; e.alu_b_sel = 1'b1; e.imm_type = 3'd1;
        step("sw/ex", 1'b1, e);
        e = '0; e.mem_req = 1'b1; e.mem_we = 1'b1; e.mem_addr_sel = 1'b1; e.mem_funct3 = 3'b010;
        step("sw/mem_wait", 1'b0, e);
        e.pc_we = 1'b1; e.retire = 1'b1;
        step("sw/mem_rdy", 1'b1, e);
        exp_ret++;

        run_br("beq_taken", 32'h0020_8463, 1'b1, 3'b000);
        run_br("bne_not",   32'h0020_9463, 1'b0, 3'b001);

        front("jal", 32'h0100_00EF);
        e = '0; e.reg_we = 1'b1; e.wb_sel = 2'd2; e.pc_sel = 2'd1; e.imm_type = 3'd4;
        e.pc_we = 1'b1; e.retire = 1'b1;
        step("jal/ex", 1'b1, e);
        exp_ret++;

        front("jalr", 32'h0002_80E7);
        e = '0; e.alu_b_sel = 1'b1; e.reg_we = 1'b1; e.wb_sel = 2'd2; e.pc_sel = 2'd2;
        e.pc_we = 1'b1; e.retire = 1'b1;
        step("jalr/ex", 1'b1, e);
        exp_ret++;

        // Reset asserted in the middle of a stalled store
        front("sw_rst", 32'h0020_A223);
        e = '0; e.alu_b_sel = 1'b1; e.imm_type = 3'd1;
        step("sw_rst/ex", 1'b1, e);
        e = '0; e.mem_req = 1'b1; e.mem_we = 1'b1; e.mem_addr_sel = 1'b1; e.mem_funct3 = 3'b010;
        step("sw_rst/mem_wait", 1'b0, e);
        check("sw_rst/cnt_before", 64'(instret), 64'(exp_ret));
        #2 rst_n = 1'b0;
        #1;
        check("sw_rst/async_drop", 64'(observe()), 64'(0));
        exp_ret = 0;
        check("sw_rst/cnt_clear", 64'(instret), 64'(exp_ret));
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("sw_rst/restart", 64'(observe()), 64'(fetch_ctl(1'b0)));

        run_wb("add_after", 32'h0020_81B3, 4'd0, 2'd0, 1'b0, 3'd0, 1'b1);

        for (int i = 0; i < 4; i++) run_illegal($sformatf("illegal%0d", i), bad[i]);

        run_wb("addi_final", 32'h0010_0013, 4'd0, 2'd0, 1'b1, 3'd0, 1'b0);
        @(negedge clk);
        #1;
        check("final_cnt", 64'(instret), 64'(exp_ret));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
